mipi_hs_lane_tx: RTL and testbench
==================================

// Module: mipi_hs_lane_tx
// PURPOSE
//  Byte-level D-PHY high-speed lane transmit sequencer, the transmit counterpart of the lane
//  receiver's sync-byte aligner. Takes payload bytes over a valid/ready stream and frames each
//  packet as HS-zero preamble, sync byte 0xB8, payload and HS-trail. Drives the parallel byte
//  input and HS-enable of the lane serializer. Bytes are serialized LSB first.
// PARAMETERS
//  PREP_BYTES   4      HS-zero (0x00) bytes before the sync byte; range 1..255
//  TRAIL_BYTES  2      HS-trail bytes after the last payload byte; range 1..255
//  IDLE_GAP     2      minimum hs_en-low cycles between packets; range 1..255
//  SYNC_BYTE    8'hB8  leader/sync byte value
// PORTS
//  clk       in   1  byte clock
//  rst_n     in   1  asynchronous active-low reset
//  s_valid   in   1  payload byte valid
//  s_data    in   8  payload byte
//  s_last    in   1  marks the final byte of the packet
//  s_ready   out  1  payload byte accepted when s_valid & s_ready
//  hs_byte   out  8  byte to serializer (LSB transmitted first)
//  hs_en     out  1  lane in HS mode; serializer drives hs_byte only while high
//  sot       out  1  one-cycle pulse while SYNC_BYTE is on hs_byte
//  eot       out  1  one-cycle pulse while the final trail byte is on hs_byte
//  underrun  out  1  one-cycle pulse on the first trail byte of an aborted packet
//  busy      out  1  high whenever state != IDLE
// BEHAVIOUR
//  - Reset (async assert, sync release): state IDLE, gap counter 0, hs_byte 0x00, hs_en 0,
//    sot/eot/underrun 0, s_ready 0, busy 0.
//  - All outputs except s_ready are registered. s_ready is decoded from the state register only,
//    with no combinational path from s_valid.
//  - The state names the phase currently shown on hs_byte: IDLE, PREP, SYNC, DATA, TRAIL.
//  - IDLE: hs_en 0, hs_byte 0x00. If s_valid=1 and gap counter = 0, go to PREP at the next edge.
//    hs_en rises on that edge.
//  - PREP: hs_byte 0x00 for exactly PREP_BYTES cycles, then SYNC.
//  - SYNC: hs_byte = SYNC_BYTE and sot = 1 for one cycle. s_ready = 1.
//  - DATA: s_ready = 1. A byte accepted in cycle N appears on hs_byte in cycle N+1 (latency 1).
//    The same rule applies to the first byte accepted during SYNC.
//  - Accepting a byte with s_last=1 goes to TRAIL after that byte is shown; s_ready is 0 in TRAIL.
//  - Underrun: s_valid=0 while in SYNC or DATA aborts the packet. The next cycle enters TRAIL with
//    underrun=1 on that cycle. The D-PHY lane cannot stall, so there is no wait state.
//  - TRAIL: hs_byte = {8{~b}} for TRAIL_BYTES cycles, where b is bit 7 of the last byte shown
//    (payload byte, or SYNC_BYTE if aborted in SYNC). eot = 1 on the final trail cycle, then IDLE.
//  - Gap: on TRAIL->IDLE the gap counter loads IDLE_GAP-1 and decrements each IDLE cycle
//    (saturating at 0). If s_valid is held high, hs_en stays low for exactly IDLE_GAP cycles.
//  - Packet length is unbounded; there is no internal byte counter on payload.
//    Counter widths are 8 bits.
//  - Reset mid-packet: hs_en drops immediately (async) and the trail is not emitted.
//    The next packet starts with a full PREP.
//  - s_last with s_valid=0 is ignored. s_data/s_last are don't-care when s_ready=0.
// TESTING
//  1 Defaults, payload A5,3C,81 (last on 81) -> hs_en high 10 cycles:
//    00,00,00,00,B8,A5,3C,81,00,00; sot on B8, eot on final 00.
//  2 Payload 12,7F -> trail FF,FF (bit7 of 7F = 0); no underrun pulse.
//  3 Send 12, then s_valid=0 in DATA -> hs_byte 12,FF,FF; underrun on first FF; eot on second.
//  4 Two back-to-back packets with s_valid held high -> hs_en low exactly 2 cycles between eot and
//    next PREP; second packet fully framed.
//  5 rst_n low while 3C is on hs_byte -> same instant hs_en=0, s_ready=0, busy=0.
//    Next packet after release starts with 4x00.
//  6 PREP_BYTES=1, TRAIL_BYTES=1, single byte 80 with s_last -> hs_byte 00,B8,80,00; sot, eot each
//    one cycle.

Source files
------------

// File: rtl/mipi_hs_lane_tx.sv
// D-PHY high-speed lane transmit sequencer.
// Frames each packet from a valid/ready byte stream as HS-zero preamble, sync byte,
// payload and HS-trail, and drives the serializer's parallel byte and HS-enable.
// The state register always names the phase currently shown on hs_byte, so every
// output except s_ready is computed from the next state and registered.
module mipi_hs_lane_tx #(
  parameter int         PREP_BYTES  = 4,
  parameter int         TRAIL_BYTES = 2,
  parameter int         IDLE_GAP    = 2,
  parameter logic [7:0] SYNC_BYTE   = 8'hB8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  input  logic       s_last,
  output logic       s_ready,
  output logic [7:0] hs_byte,
  output logic       hs_en,
  output logic       sot,
  output logic       eot,
  output logic       underrun,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PREP  = 3'd1,
    SYNC  = 3'd2,
    DATA  = 3'd3,
    TRAIL = 3'd4
  } state_t;

  // Counter preloads: each phase counts down to zero on its final cycle.
  localparam logic [7:0] PREP_LOAD  = 8'(PREP_BYTES - 1);
  localparam logic [7:0] TRAIL_LOAD = 8'(TRAIL_BYTES - 1);
  localparam logic [7:0] GAP_LOAD   = 8'(IDLE_GAP - 1);

  state_t     state_reg, state_next;
  logic [7:0] cnt_reg, cnt_next;     // shared PREP / TRAIL phase counter
  logic [7:0] gap_reg, gap_next;     // inter-packet idle counter
  logic [7:0] byte_reg, byte_next;   // byte currently on the lane
  logic       last_reg, last_next;   // byte on the lane is the packet's final byte
  logic       sot_reg, sot_next;
  logic       eot_reg, eot_next;
  logic       und_reg, und_next;
  logic [7:0] trail_fill;

  // Trail level is the inverse of the final bit of the last byte shown.
  assign trail_fill = {8{~byte_reg[7]}};

  // Ready only while a payload byte can be taken: SYNC, or DATA before the last byte.
  assign s_ready  = (state_reg == SYNC) || ((state_reg == DATA) && !last_reg);

  assign hs_byte  = byte_reg;
  assign hs_en    = (state_reg != IDLE);
  assign busy     = (state_reg != IDLE);
  assign sot      = sot_reg;
  assign eot      = eot_reg;
  assign underrun = und_reg;

  // Next-state and next-output decode.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    gap_next   = gap_reg;
    byte_next  = byte_reg;
    last_next  = last_reg;
    sot_next   = 1'b0;
    eot_next   = 1'b0;
    und_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        byte_next = 8'h00;
        if (gap_reg != 8'd0) begin
          gap_next = gap_reg - 8'd1;
        end else if (s_valid) begin
          state_next = PREP;
          cnt_next   = PREP_LOAD;
        end
      end
      PREP: begin
        if (cnt_reg == 8'd0) begin
          state_next = SYNC;
          byte_next  = SYNC_BYTE;
          sot_next   = 1'b1;
          last_next  = 1'b0;
        end else begin
          cnt_next = cnt_reg - 8'd1;
        end
      end
      SYNC, DATA: begin
        if (s_ready && s_valid) begin
          state_next = DATA;
          byte_next  = s_data;
          last_next  = s_last;
        end else begin
          // Either the final byte has been shown or the source ran dry; the
          // lane cannot stall, so both go straight into the trail.
          state_next = TRAIL;
          byte_next  = trail_fill;
          cnt_next   = TRAIL_LOAD;
          eot_next   = (TRAIL_LOAD == 8'd0);
          und_next   = s_ready;
        end
      end
      TRAIL: begin
        if (cnt_reg == 8'd0) begin
          state_next = IDLE;
          byte_next  = 8'h00;
          gap_next   = GAP_LOAD;
        end else begin
          cnt_next = cnt_reg - 8'd1;
          eot_next = (cnt_reg == 8'd1);
        end
      end
      default: begin
        state_next = IDLE;
        byte_next  = 8'h00;
      end
    endcase
  end

  // State and output registers; reset drops the lane out of HS immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 8'd0;
      gap_reg   <= 8'd0;
      byte_reg  <= 8'h00;
      last_reg  <= 1'b0;
      sot_reg   <= 1'b0;
      eot_reg   <= 1'b0;
      und_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      gap_reg   <= gap_next;
      byte_reg  <= byte_next;
      last_reg  <= last_next;
      sot_reg   <= sot_next;
      eot_reg   <= eot_next;
      und_reg   <= und_next;
    end
  end

endmodule

// File: tb/tb_mipi_hs_lane_tx.sv
// Testbench for mipi_hs_lane_tx: drives packets, captures each HS burst and
// compares it with the frame built from the packet contents.
module tb_mipi_hs_lane_tx;

  localparam int PREP  = 4;
  localparam int TRAIL = 2;
  localparam int GAP   = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_valid, s_last, s_ready;
  logic [7:0] s_data, hs_byte;
  logic       hs_en, sot, eot, underrun, busy;

  // Second instance with the shortest preamble and trail.
  logic       v1, l1, r1, en1, so1, eo1, u1, bz1;
  logic [7:0] d1, hb1;

  int ncmp = 0;
  int nerr = 0;
  logic [7:0] pl[$];

  always #5 clk = ~clk;

  mipi_hs_lane_tx #(.PREP_BYTES(PREP), .TRAIL_BYTES(TRAIL), .IDLE_GAP(GAP), .SYNC_BYTE(8'hB8)) u_dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready), .hs_byte(hs_byte), .hs_en(hs_en), .sot(sot), .eot(eot),
    .underrun(underrun), .busy(busy));

  mipi_hs_lane_tx #(.PREP_BYTES(1), .TRAIL_BYTES(1), .IDLE_GAP(2), .SYNC_BYTE(8'hB8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .s_valid(v1), .s_data(d1), .s_last(l1),
    .s_ready(r1), .hs_byte(hb1), .hs_en(en1), .sot(so1), .eot(eo1),
    .underrun(u1), .busy(bz1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Send pl[0..keep-1] as one packet of nominal length n (keep<n aborts it).
  // hold keeps s_valid high after the packet; chk_gap checks the preceding idle gap;
  // rst_at >= 0 pulses reset while frame position rst_at is on the lane.
  task automatic run_packet(input int n, input int keep, input bit hold,
                            input bit chk_gap, input int rst_at);
    logic [7:0] cb[$];
    bit cs[$], ce[$], cu[$], cz[$];
    int idx = 0, low = 0, elen;
    bit seen = 0, done = 0, rst_done = 0;
    logic [7:0] lastb, fill, eb;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      @(negedge clk);
      if (hs_en) begin
        seen = 1;
        cb.push_back(hs_byte); cs.push_back(sot); ce.push_back(eot);
        cu.push_back(underrun); cz.push_back(busy);
      end else if (seen) begin
        done = 1;
      end else begin
        low++;
      end
      if (!done && rst_at >= 0 && cb.size() == rst_at + 1) begin
        rst_n = 1'b0;
        #1;
        check("rst_mid_hs_en", hs_en, 0);
        check("rst_mid_s_ready", s_ready, 0);
        check("rst_mid_busy", busy, 0);
        s_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        done = 1;
        rst_done = 1;
      end
      if (!done) begin
        if (s_ready) begin
          if (idx < keep) begin
            s_valid = 1'b1; s_data = pl[idx]; s_last = (idx == n - 1); idx++;
          end else begin
            s_valid = 1'b0; s_data = 8'($urandom); s_last = 1'($urandom);
          end
        end else if (!seen) begin
          s_valid = 1'b1; s_data = 8'($urandom); s_last = 1'($urandom);
        end else begin
          s_valid = hold;
        end
      end
    end
    if (!done) begin
      check("timeout", 1, 0);
      return;
    end
    if (rst_done) begin
      $display("packet reset at pos %0d", rst_at);
      return;
    end
    // Expected frame: PREP zeros, sync, kept payload, trail of ~bit7 of last byte shown.
    lastb = (keep > 0) ? pl[keep-1] : 8'hB8;
    fill  = lastb[7] ? 8'h00 : 8'hFF;
    elen  = PREP + 1 + keep + TRAIL;
    check("frame_len", cb.size(), elen);
    for (int i = 0; i < elen && i < cb.size(); i++) begin
      if (i < PREP) eb = 8'h00;
      else if (i == PREP) eb = 8'hB8;
      else if (i < PREP + 1 + keep) eb = pl[i-PREP-1];
      else eb = fill;
      check($sformatf("byte[%0d]", i), cb[i], eb);
      check($sformatf("sot[%0d]", i), cs[i], i == PREP);
      check($sformatf("eot[%0d]", i), ce[i], i == elen - 1);
      check($sformatf("underrun[%0d]", i), cu[i], (keep < n) && (i == PREP + 1 + keep));
      check($sformatf("busy[%0d]", i), cz[i], 1);
    end
    check("idle_byte", hs_byte, 8'h00);
    check("idle_busy", busy, 0);
    if (chk_gap) check("gap_len", low + 1, GAP);
    $display("packet n=%0d keep=%0d len=%0d", n, keep, cb.size());
  endtask

  initial begin
    logic [7:0] e6 [4];
    logic [7:0] c6 [$];
    bit s6 [$], t6 [$];
    int n, keep;
    bit hold, prev_hold;
    s_valid = 0; s_data = 0; s_last = 0;
    v1 = 0; d1 = 0; l1 = 0;
    rst_n = 0;
    #2;
    check("rst_hs_en", hs_en, 0);
    check("rst_hs_byte", hs_byte, 8'h00);
    check("rst_s_ready", s_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_sot_eot_und", {sot, eot, underrun}, 3'b000);
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("idle_hs_en", hs_en, 0);

    // Spec example 1: A5,3C,81.
    pl = '{8'hA5, 8'h3C, 8'h81};
    run_packet(3, 3, 0, 0, -1);
    repeat (3) @(negedge clk);
    // Example 2: 12,7F -> FF trail.
    pl = '{8'h12, 8'h7F};
    run_packet(2, 2, 0, 0, -1);
    repeat (3) @(negedge clk);
    // Example 3: underrun after 12.
    pl = '{8'h12, 8'h55};
    run_packet(2, 1, 0, 0, -1);
    repeat (3) @(negedge clk);
    // Abort in SYNC: trail follows bit 7 of the sync byte.
    pl = '{8'h01};
    run_packet(1, 0, 0, 0, -1);
    repeat (3) @(negedge clk);
    // Example 4: back-to-back with s_valid held.
    pl = '{8'h11, 8'h92};
    run_packet(2, 2, 1, 0, -1);
    pl = '{8'h33, 8'hC4, 8'h05};
    run_packet(3, 3, 0, 1, -1);
    repeat (3) @(negedge clk);
    // Example 5: reset while 3C is on the lane, then a full packet.
    pl = '{8'hA5, 8'h3C, 8'h81};
    run_packet(3, 3, 0, 0, PREP + 2);
    pl = '{8'h6E};
    run_packet(1, 1, 0, 0, -1);
    repeat (3) @(negedge clk);

    // Randomized packets.
    prev_hold = 0;
    for (int p = 0; p < 10; p++) begin
      n = $urandom_range(1, 6);
      keep = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : n;
      hold = 1'($urandom);
      pl.delete();
      for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
      run_packet(n, keep, hold, prev_hold, -1);
      prev_hold = hold;
    end
    s_valid = 0;
    repeat (4) @(negedge clk);

    // Example 6: PREP=1, TRAIL=1, single byte 80.
    e6 = '{8'h00, 8'hB8, 8'h80, 8'h00};
    v1 = 1; d1 = 8'h80; l1 = 1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (en1) begin
        c6.push_back(hb1); s6.push_back(so1); t6.push_back(eo1);
      end else if (c6.size() > 0) begin
        break;
      end
    end
    v1 = 0;
    check("p6_len", c6.size(), 4);
    for (int i = 0; i < 4 && i < c6.size(); i++) begin
      check($sformatf("p6_byte[%0d]", i), c6[i], e6[i]);
      check($sformatf("p6_sot[%0d]", i), s6[i], i == 1);
      check($sformatf("p6_eot[%0d]", i), t6[i], i == 3);
    end
    $display("packet short-params len=%0d", c6.size());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
